// File: rtl/dmem_host_bridge.sv
// ---------------------------------------------------------------------------
// dmem_host_bridge
//
// This bridge is the hardware version of the host-side "load memory, run the
// core, dump memory" sequence. A go pulse starts the sequence:
//   1. LOAD     : host words on in_data are written to DMEM at addresses
//                 0 .. LOAD_WORDS-1.
//   2. START/RUN: the core gets a one-cycle START pulse. The bridge then
//                 waits for the core END level.
//   3. DUMP     : DMEM words DUMP_BASE .. DUMP_BASE+DUMP_WORDS-1 are read
//                 back and streamed to the host with a valid/ready handshake.
//   4. DONE     : done stays high until the next go pulse.
// The bridge also drives the top-level DMEM mux select, so the core, the
// loader and the reader never share the memory port.
//
// Ports:
//   clk, RESET          system clock; asynchronous active-high reset
//   go                  start pulse, only acted on in IDLE or DONE
//   in_data/valid/ready host -> DMEM load stream
//   out_data/valid/ready DMEM -> host dump stream
//   mem_addr/wdata/we   DMEM port used by the load and dump paths
//   mem_rdata           DMEM read data, valid RD_LAT cycles after mem_addr
//   addr_mux_select     0 = core, 1 = load path, 2 = dump path
//   core_start/core_end START pulse to the core / END level from the core
//   busy, done          sequence status
// ---------------------------------------------------------------------------
module dmem_host_bridge #(
  parameter int LOAD_WORDS = 1000,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 997,
  parameter int RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        go,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  addr_mux_select,
  output logic        core_start,
  input  logic        core_end,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_OUT,
    DONE
  } state_t;

  localparam logic [15:0] LoadLast = 16'(LOAD_WORDS - 1);
  localparam logic [15:0] DumpLast = 16'(DUMP_WORDS - 1);
  localparam logic [15:0] DumpBase = 16'(DUMP_BASE);
  localparam logic [7:0]  WaitLast = 8'(RD_LAT - 1);

  localparam logic [1:0] MuxCore = 2'd0;
  localparam logic [1:0] MuxLoad = 2'd1;
  localparam logic [1:0] MuxDump = 2'd2;

  state_t      state_q, state_d;
  logic [15:0] loadCnt_q, loadCnt_d;
  logic [15:0] dumpCnt_q, dumpCnt_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [15:0] outData_q, outData_d;
  logic [15:0] dumpAddr;

  // The dump address wraps modulo 2^16 because the sum is kept at 16 bits.
  assign dumpAddr = DumpBase + dumpCnt_q;
  assign out_data = outData_q;

  // State, counters and the captured dump word. An asserted reset aborts any
  // sequence at once. Every output is decoded from the state, so all of them
  // fall to 0 in the same instant.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      loadCnt_q <= '0;
      dumpCnt_q <= '0;
      waitCnt_q <= '0;
      outData_q <= '0;
    end else begin
      state_q   <= state_d;
      loadCnt_q <= loadCnt_d;
      dumpCnt_q <= dumpCnt_d;
      waitCnt_q <= waitCnt_d;
      outData_q <= outData_d;
    end
  end

  // Next-state and output decode. Defaults leave the core as the DMEM owner
  // and keep every strobe low. Each state overrides only what it drives.
  always_comb begin
    state_d         = state_q;
    loadCnt_d       = loadCnt_q;
    dumpCnt_d       = dumpCnt_q;
    waitCnt_d       = waitCnt_q;
    outData_d       = outData_q;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_we          = 1'b0;
    addr_mux_select = MuxCore;
    core_start      = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (go) begin
          loadCnt_d = '0;
          dumpCnt_d = '0;
          waitCnt_d = '0;
          state_d   = (LOAD_WORDS == 0) ? START : LOAD;
        end
      end

      // The write goes out in the cycle the host word is accepted. Once the
      // last word is in, the state leaves LOAD, so in_ready is already low
      // in the following cycle.
      LOAD: begin
        addr_mux_select = MuxLoad;
        in_ready        = 1'b1;
        mem_addr        = loadCnt_q;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          loadCnt_d = loadCnt_q + 16'd1;
          if (loadCnt_q == LoadLast) begin
            state_d = START;
          end
        end
      end

      START: begin
        core_start = 1'b1;
        state_d    = RUN;
      end

      // core_end is only examined from this state onwards. An END level that
      // was already high during START is therefore not seen until here.
      RUN: begin
        if (core_end) begin
          state_d = (DUMP_WORDS == 0) ? DONE : DUMP_RD;
        end
      end

      // The dump address is held through the read latency. A zero-latency
      // memory is captured directly.
      DUMP_RD: begin
        addr_mux_select = MuxDump;
        mem_addr        = dumpAddr;
        if (RD_LAT == 0) begin
          outData_d = mem_rdata;
          state_d   = DUMP_OUT;
        end else begin
          waitCnt_d = '0;
          state_d   = DUMP_WAIT;
        end
      end

      DUMP_WAIT: begin
        addr_mux_select = MuxDump;
        mem_addr        = dumpAddr;
        if (waitCnt_q == WaitLast) begin
          outData_d = mem_rdata;
          state_d   = DUMP_OUT;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      // out_data is a register, so it stays stable for as long as the host
      // applies backpressure.
      DUMP_OUT: begin
        addr_mux_select = MuxDump;
        mem_addr        = dumpAddr;
        out_valid       = 1'b1;
        if (out_ready) begin
          dumpCnt_d = dumpCnt_q + 16'd1;
          state_d   = (dumpCnt_q == DumpLast) ? DONE : DUMP_RD;
        end
      end

      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (go) begin
          loadCnt_d = '0;
          dumpCnt_d = '0;
          waitCnt_d = '0;
          state_d   = (LOAD_WORDS == 0) ? START : LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
